multi_wave_gen: RTL and testbench
=================================

Name: multi_wave_gen

Overview:
- Parametrised stepped oscillator for the synth voice path.
- Generates triangle, sawtooth-up or square (programmable duty) waveforms of 2^STEPS_LOG2 steps per cycle.
- Period, mode and duty are loaded through a valid/ready handshake and applied glitch-free at the next cycle boundary.
- Output feeds the mixer/DAC stage as an unsigned sample.

Parameters:
OUT_W, 8, output sample width; MAX = 2^OUT_W-1
PERIOD_W, 32, period input width (clock cycles per waveform cycle)
STEPS_LOG2, 3, log2 of steps per cycle (STEPS = 2^STEPS_LOG2); legal range 1..8
RESET_PERIOD, 1024, active period after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run when high; when low, hold at step 0 and output 0
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  pending slot free; config accepted on cfg_valid&&cfg_ready
cfg_period  in  PERIOD_W  requested period in clocks
cfg_mode  in  2  00 triangle, 01 saw-up, 10 square, 11 mute
cfg_duty  in  STEPS_LOG2+1  square high steps, 0..STEPS (values >STEPS clamp to STEPS)
value  out  OUT_W  registered sample
cycle_start  out  1  one-clock pulse marking start of step 0

Behaviour:
- Reset (async): t=0, k=0, value=0, cycle_start=0, cfg_ready=1, active period=RESET_PERIOD, mode=triangle, duty=STEPS/2, pending empty.
- Step length: step_len = max(period>>STEPS_LOG2, 1). t counts 0..step_len-1 and k advances on the edge where t==step_len-1. k wraps STEPS-1 -> 0 (the "wrap edge"). Waveform cycle = STEPS*step_len clocks.
- enable low: t and k are forced to 0 and value is registered to 0. At the first edge with enable=1, step 0 begins: t goes to 1 (or k advances if step_len=1).
- value is registered from the step index valid after the edge, so it always matches the current k with zero lag. All products and shifts use OUT_W+STEPS_LOG2+1 bits.
- Triangle (H = STEPS/2): k<H gives ((k+1)*MAX)>>(STEPS_LOG2-1); k>=H gives ((STEPS-k)*MAX)>>(STEPS_LOG2-1).
- Saw-up: ((k+1)*MAX)>>STEPS_LOG2.
- Square: MAX if k<duty, else 0.
- Mute: 0.
- cycle_start is 1 for exactly the cycle following a wrap edge or the first enabled edge; otherwise 0.
- Config handshake:
  - Accept on cfg_valid&&cfg_ready. The values go to the pending register and cfg_ready drops on the next cycle.
  - Pending is applied to active on the next wrap edge, or on the next edge while enable=0. cfg_ready returns high the cycle after apply.
  - An accept on the same edge as a wrap defers application to the following wrap.
  - A second offer while cfg_ready=0 is ignored; the requester must hold cfg_valid.
  - Application resets neither t nor k beyond the normal wrap behaviour.
- Period 0..STEPS-1 gives step_len=1, one step per clock.
- Reset asserted mid-cycle discards pending config and restores the defaults.

Decomposition:
- Package synth_wave_pkg: mode encodings (WAVE_TRI, WAVE_SAW, WAVE_SQR, WAVE_MUTE) and a cfg struct typedef {period, mode, duty}.
- Sub-module step_timer: t counter, k index, wrap and first-enable pulse generation. Parameters PERIOD_W and STEPS_LOG2; inputs enable and step_len.
- multi_wave_gen keeps the cfg handshake, the active/pending registers and the shape computation.

Test Plan (OUT_W=8, STEPS_LOG2=3):
- Reset, enable=1, default config -> step_len=128; value sequence 63,127,191,255,255,191,127,63 with each value held 128 clocks; cycle_start pulses every 1024 clocks.
- Config period=64, mode=saw offered mid-cycle -> accepted at once; triangle completes its cycle, then saw 31,63,95,127,159,191,223,255 at 8 clocks per step; cfg_ready high one cycle after the wrap.
- Square with duty=3, period=16 -> 255 for 6 clocks, then 0 for 10 clocks, repeating; duty=0 gives constant 0; duty=8 gives constant 255.
- Config offered while enable=0 -> applied on the next edge; on enable rise, value=f(0) and cycle_start pulses once.
- cfg_valid held with a second config while cfg_ready=0 -> not accepted until cfg_ready rises; the first config applies at the wrap, the second at the following wrap.
- Reset asserted mid-step with a pending config -> value=0, cfg_ready=1 immediately; RESET_PERIOD triangle resumes and the pending config is lost.

Source files
------------

// File: rtl/synth_wave_pkg.sv
// Shared types for the synth voice oscillator: waveform mode encodings,
// the configuration record and the step-length helper.
package synth_wave_pkg;

    // Storage width of the configuration fields; the period field is wide
    // enough for any PERIOD_W up to 64, the duty field for STEPS up to 256.
    localparam int CFG_PERIOD_W = 64;
    localparam int CFG_DUTY_W   = 9;

    typedef enum logic [1:0] {
        WAVE_TRI  = 2'b00,
        WAVE_SAW  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_MUTE = 2'b11
    } wave_mode_e;

    typedef struct packed {
        logic [CFG_PERIOD_W-1:0] period;
        wave_mode_e              mode;
        logic [CFG_DUTY_W-1:0]   duty;
    } wave_cfg_t;

    // Clocks per step: period / STEPS, never less than one clock.
    function automatic logic [CFG_PERIOD_W-1:0] step_len_of(
        input logic [CFG_PERIOD_W-1:0] period,
        input int unsigned             steps_log2
    );
        logic [CFG_PERIOD_W-1:0] len;
        len = period >> steps_log2;
        return (len == '0) ? CFG_PERIOD_W'(1) : len;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer: in-step clock counter t, step index k, wrap-edge strobe and
// the registered cycle_start pulse (after a wrap or the first enabled edge).
module step_timer
    import synth_wave_pkg::*;
#(
    parameter int PERIOD_W   = 32,
    parameter int STEPS_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PERIOD_W-1:0]   step_len,
    output logic [STEPS_LOG2-1:0] k_next,
    output logic                  wrap,
    output logic                  cycle_start
);

    logic [PERIOD_W-1:0]   t_q, t_d;
    logic [STEPS_LOG2-1:0] k_q, k_d;
    logic                  en_q, en_d;
    logic                  cycle_start_q, cycle_start_d;
    logic                  step_end;
    logic                  first_edge;

    // Advance t within a step, k at step end; hold both at zero while disabled.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        t_d        = t_q;
        k_d        = k_q;
        en_d       = enable;
        wrap       = 1'b0;
        // >= rather than == keeps the counter safe if step_len ever shrinks under it.
        step_end   = (t_q >= step_len - PERIOD_W'(1));
        first_edge = enable && !en_q;
        if (!enable) begin
            t_d = '0;
            k_d = '0;
        end else if (step_end) begin
            t_d  = '0;
            k_d  = k_q + STEPS_LOG2'(1);
            wrap = (k_q == '1);
        end else begin
            t_d = t_q + PERIOD_W'(1);
        end
        cycle_start_d = wrap || first_edge;
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q           <= '0;
            k_q           <= '0;
            en_q          <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            t_q           <= t_d;
            k_q           <= k_d;
            en_q          <= en_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    // k_next is the index valid after this edge, letting the sample register track k with no lag.
    assign k_next      = k_d;
    assign cycle_start = cycle_start_q;

endmodule

// File: rtl/multi_wave_gen.sv
// Stepped multi-waveform oscillator: configuration handshake with a single
// pending slot, active configuration swapped at cycle boundaries, and the
// registered triangle / saw-up / square / mute sample.
module multi_wave_gen
    import synth_wave_pkg::*;
#(
    parameter int OUT_W        = 8,
    parameter int PERIOD_W     = 32,
    parameter int STEPS_LOG2   = 3,
    parameter int RESET_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [1:0]            cfg_mode,
    input  logic [STEPS_LOG2:0]   cfg_duty,
    output logic [OUT_W-1:0]      value,
    output logic                  cycle_start
);

    localparam int STEPS  = 1 << STEPS_LOG2;
    localparam int PROD_W = OUT_W + STEPS_LOG2 + 1;
    localparam logic [PROD_W-1:0] MAX_P = PROD_W'({OUT_W{1'b1}});
    localparam wave_cfg_t RESET_CFG = '{
        period: CFG_PERIOD_W'(RESET_PERIOD),
        mode:   WAVE_TRI,
        duty:   CFG_DUTY_W'(STEPS / 2)
    };

    wave_cfg_t             active_q, active_d;
    wave_cfg_t             pending_q, pending_d;
    logic                  pend_v_q, pend_v_d;
    logic [OUT_W-1:0]      value_q, value_d;
    logic                  accept;
    logic                  apply;
    logic [PERIOD_W-1:0]   step_len;
    logic [STEPS_LOG2-1:0] k_next;
    logic                  wrap;

    // Sample for step k under the given mode; products are wide enough for STEPS*MAX.
    function automatic logic [OUT_W-1:0] shape(
        input wave_mode_e            mode,
        input logic [CFG_DUTY_W-1:0] duty,
        input logic [STEPS_LOG2-1:0] k
    );
        logic [PROD_W-1:0]     kk;
        logic [PROD_W-1:0]     prod;
        logic [CFG_DUTY_W-1:0] duty_c;
        kk     = PROD_W'(k);
        prod   = '0;
        duty_c = (duty > CFG_DUTY_W'(STEPS)) ? CFG_DUTY_W'(STEPS) : duty;
        case (mode)
            WAVE_TRI: begin
                if (kk < PROD_W'(STEPS / 2))
                    prod = ((kk + PROD_W'(1)) * MAX_P) >> (STEPS_LOG2 - 1);
                else
                    prod = ((PROD_W'(STEPS) - kk) * MAX_P) >> (STEPS_LOG2 - 1);
            end
            WAVE_SAW: prod = ((kk + PROD_W'(1)) * MAX_P) >> STEPS_LOG2;
            WAVE_SQR: prod = (CFG_DUTY_W'(k) < duty_c) ? MAX_P : '0;
            default:  prod = '0;
        endcase
        return OUT_W'(prod);
    endfunction

    assign step_len = PERIOD_W'(step_len_of(active_q.period, STEPS_LOG2));

    step_timer #(
        .PERIOD_W   (PERIOD_W),
        .STEPS_LOG2 (STEPS_LOG2)
    ) u_step_timer (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .step_len    (step_len),
        .k_next      (k_next),
        .wrap        (wrap),
        .cycle_start (cycle_start)
    );

    // Handshake, pending-to-active swap at a boundary, and next sample.
    always_comb begin
        accept    = cfg_valid && !pend_v_q;
        // An accept can never coincide with an apply: the slot is either empty or full.
        apply     = pend_v_q && (wrap || !enable);
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        if (apply) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pending_d = '{
                period: CFG_PERIOD_W'(cfg_period),
                mode:   wave_mode_e'(cfg_mode),
                duty:   CFG_DUTY_W'(cfg_duty)
            };
            pend_v_d = 1'b1;
        end
        // Use the post-edge config so a swap at the wrap shapes step 0 of the new cycle.
        value_d = enable ? shape(active_d.mode, active_d.duty, k_next) : '0;
    end

    // Configuration and sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= RESET_CFG;
            // NOTE: the pending slot is reset too, so a config half-way through the handshake is dropped.
            pending_q <= RESET_CFG;
            pend_v_q  <= 1'b0;
            value_q   <= '0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            value_q   <= value_d;
        end
    end

    assign cfg_ready = !pend_v_q;
    assign value     = value_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Scoreboard bench for multi_wave_gen: the driver applies stimulus, steps a
// phase-based reference model and queues the expected sample; a monitor pops
// and compares every cycle.
module tb_multi_wave_gen;

    localparam int OUT_W        = 8;
    localparam int PERIOD_W     = 32;
    localparam int SL           = 3;
    localparam int RESET_PERIOD = 1024;
    localparam int STEPS        = 1 << SL;
    localparam int MAXV         = (1 << OUT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [PERIOD_W-1:0] cfg_period;
    logic [1:0]          cfg_mode;
    logic [SL:0]         cfg_duty;
    logic [OUT_W-1:0]    value;
    logic                cycle_start;

    always #5 clk = ~clk;

    multi_wave_gen #(
        .OUT_W        (OUT_W),
        .PERIOD_W     (PERIOD_W),
        .STEPS_LOG2   (SL),
        .RESET_PERIOD (RESET_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .value       (value),
        .cycle_start (cycle_start)
    );

    typedef struct {
        logic [OUT_W-1:0] value;
        logic             cs;
        logic             ready;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: position within the waveform cycle counted in clocks.
    int m_pos, m_per, m_mode, m_duty;
    int p_per, p_mode, p_duty;
    bit m_en_prev, m_pend, m_accepted;

    function automatic int len_of(input int per);
        int l;
        l = per >> SL;
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int shape_ref(input int mode, input int duty, input int k);
        int d;
        case (mode)
            0: begin
                if (k < STEPS / 2) return ((k + 1) * MAXV) >> (SL - 1);
                else               return ((STEPS - k) * MAXV) >> (SL - 1);
            end
            1: return ((k + 1) * MAXV) >> SL;
            2: begin
                d = (duty > STEPS) ? STEPS : duty;
                return (k < d) ? MAXV : 0;
            end
            default: return 0;
        endcase
    endfunction

    // One clock: drive inputs after the sampling edge, advance the model, queue the result.
    task automatic drive(input bit rst, input bit en, input bit vld,
                         input int per, input int mode, input int duty);
        exp_t e;
        int   len, total, k;
        bit   wrap, first, acc, app;
        @(negedge clk);
        #1;
        reset      = rst;
        enable     = en;
        cfg_valid  = vld;
        cfg_period = PERIOD_W'(per);
        cfg_mode   = 2'(mode);
        cfg_duty   = (SL + 1)'(duty);
        if (rst) begin
            m_pos = 0; m_en_prev = 1'b0; m_pend = 1'b0; m_accepted = 1'b0;
            m_per = RESET_PERIOD; m_mode = 0; m_duty = STEPS / 2;
            e.value = '0; e.cs = 1'b0; e.ready = 1'b1;
        end else begin
            len   = len_of(m_per);
            total = len * STEPS;
            wrap  = en && (m_pos == total - 1);
            first = en && !m_en_prev;
            acc   = vld && !m_pend;
            app   = m_pend && (wrap || !en);
            m_pos     = en ? (m_pos + 1) % total : 0;
            m_en_prev = en;
            if (app) begin
                m_per = p_per; m_mode = p_mode; m_duty = p_duty; m_pend = 1'b0;
            end
            if (acc) begin
                p_per = per; p_mode = mode; p_duty = duty; m_pend = 1'b1;
            end
            m_accepted = acc;
            k       = m_pos / len_of(m_per);
            e.value = en ? OUT_W'(shape_ref(m_mode, m_duty, k)) : '0;
            e.cs    = wrap || first;
            e.ready = !m_pend;
        end
        cyc++;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) drive(1'b0, en, 1'b0, 0, 0, 0);
    endtask

    // Hold cfg_valid until the handshake completes.
    task automatic offer(input int per, input int mode, input int duty, input bit en);
        int guard;
        guard = 0;
        do begin
            drive(1'b0, en, 1'b1, per, mode, duty);
            guard++;
        end while (!m_accepted && guard < 20000);
        if (!m_accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL offer_timeout: not accepted after %0d cycles, required acceptance", guard);
        end
    endtask

    // Run until the next edge is a wrap edge.
    task automatic run_to_wrap();
        int guard;
        guard = 0;
        while (m_pos != len_of(m_per) * STEPS - 1 && guard < 20000) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
            guard++;
        end
        if (m_pos != len_of(m_per) * STEPS - 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_timeout: pos=%0d after %0d cycles, required %0d", m_pos, guard,
                     len_of(m_per) * STEPS - 1);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (value !== e.value || cycle_start !== e.cs || cfg_ready !== e.ready) begin
                    n_fail++;
                    $display("FAIL sample cycle %0d: got value=%0d cycle_start=%b cfg_ready=%b, required value=%0d cycle_start=%b cfg_ready=%b",
                             e.cyc, value, cycle_start, cfg_ready, e.value, e.cs, e.ready);
                end
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int per, mode, duty;
        bit en;
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_mode = '0; cfg_duty = '0;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Default triangle after reset.
        run(2100, 1'b1);

        // Saw period 64 offered mid-cycle; applies at the triangle wrap.
        run(300, 1'b1);
        offer(64, 1, 0, 1'b1);
        run(1024 + 64 * 3, 1'b1);

        // Square duty sweep incl. 0, full and clamped.
        offer(16, 2, 3, 1'b1);
        run(64 + 16 * 4, 1'b1);
        offer(16, 2, 0, 1'b1);
        run(48, 1'b1);
        offer(16, 2, 8, 1'b1);
        run(48, 1'b1);
        offer(16, 2, 13, 1'b1);
        run(48, 1'b1);

        // Accept on the wrap edge itself defers to the following wrap.
        run_to_wrap();
        offer(40, 1, 0, 1'b1);
        run(100, 1'b1);

        // Config while disabled, then enable rise.
        run(5, 1'b0);
        offer(24, 0, 0, 1'b0);
        run(3, 1'b0);
        run(60, 1'b1);

        // Back-to-back offers: second waits for the slot.
        offer(32, 1, 0, 1'b1);
        offer(48, 2, 5, 1'b1);
        run(150, 1'b1);

        // Reset mid-step with a pending config.
        run_to_wrap();
        run(1, 1'b1);
        offer(200, 1, 0, 1'b1);
        run(5, 1'b1);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        run(2100, 1'b1);

        // Randomized configs with enable toggling, short periods and mute.
        repeat (40) begin
            per  = $urandom_range(0, 300);
            mode = $urandom_range(0, 3);
            duty = $urandom_range(0, 15);
            en   = ($urandom_range(0, 7) != 0);
            offer(per, mode, duty, en);
            run($urandom_range(0, 400), ($urandom_range(0, 5) != 0));
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
